// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared defaults, state encoding and helpers for prog_loader
//
// Contents:
//   DEF_DATA_W, DEF_ADDR_W, DEF_RUN_CYCLES - default parameter values
//   state_e                                 - loader state encoding
//   run_cnt_width()                         - width of the run down-counter
package prog_loader_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_RUN_CYCLES = 15;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    // The timer is loaded with RUN_CYCLES-1 and expires at zero, so it only
    // has to represent 0 .. RUN_CYCLES-1.
    function automatic int run_cnt_width(input int cycles);
        return (cycles < 3) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/prog_loader_run_timer.sv
// rtl/prog_loader_run_timer.sv - loadable saturating down-counter with zero flag
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset (clears count)
//   load_i       - load load_val_i (has priority over dec_i)
//   load_val_i   - value to load
//   dec_i        - decrement by one, saturating at zero
//   zero_o       - count is zero
module prog_loader_run_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program image into memory, then releases and times the core
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_data/   - program word stream; in_last marks the final word
//   in_last/in_ready
//   reload              - restart loading from address 0 (DONE or ERROR only)
//   mem_we/mem_addr/    - registered memory write port, one strobe per word
//   mem_wdata
//   core_reset          - active-high reset to the processor core
//   done                - image loaded and the run window has elapsed
//   error               - image did not end within 2**ADDR_W words
//   load_count          - words accepted in the current load
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   load_count
);

    localparam int                CNT_W    = run_cnt_width(RUN_CYCLES);
    localparam logic [CNT_W-1:0]  RUN_LOAD = CNT_W'(RUN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LCNT_ONE = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     lcnt_q, lcnt_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                core_reset_q, core_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                accept;
    logic                restart;
    logic                running;
    logic                timer_load;
    logic                timer_zero;

    assign in_ready = (state_q == ST_LOAD);
    assign accept   = in_valid & in_ready;
    assign restart  = reload && ((state_q == ST_DONE) || (state_q == ST_ERROR));
    // Only cycles with the core out of reset count towards the run window.
    assign running  = (state_q == ST_RUN) && !core_reset_q;

    prog_loader_run_timer #(
        .CNT_W (CNT_W)
    ) u_run_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (RUN_LOAD),
        .dec_i      (running),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lcnt_d       = lcnt_q;
        mem_we_d     = accept;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        timer_load   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = ST_RUN;
                    end else if (ptr_q == PTR_MAX) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_RUN: begin
                // Timer holds the remaining running cycles minus one.
                if (running && timer_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (accept) begin
            mem_addr_d  = ptr_q;
            mem_wdata_d = in_data;
            lcnt_d      = lcnt_q + LCNT_ONE;
            // The pointer never wraps; a word at the top address either ends
            // the image or sends the loader to ERROR.
            if (ptr_q != PTR_MAX) begin
                ptr_d = ptr_q + PTR_ONE;
            end
            timer_load = in_last;
        end

        if (restart) begin
            ptr_d  = '0;
            lcnt_d = '0;
        end

        // Release the core only from the second RUN cycle on, after the final
        // memory write has been committed.
        core_reset_d = !(((state_q == ST_RUN) || (state_q == ST_DONE)) &&
                         ((state_d == ST_RUN) || (state_d == ST_DONE)));
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            lcnt_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lcnt_q       <= lcnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign load_count = lcnt_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_W, default 32, memory word width.
REQ-002 Parameter ADDR_W, default 6, word address width (64-word memory).
REQ-003 Parameter RUN_CYCLES, default 15, core clock cycles to run after release.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  program word present on in_data.
REQ-007 in_data  input  DATA_W  program word.
REQ-008 in_last  input  1  final word of image; qualified by in_valid.
REQ-009 in_ready  output  1  loader accepts a word this cycle.
REQ-010 reload  input  1  in DONE or ERROR, restart loading at address 0.
REQ-011 mem_we  output  1  memory write strobe, one cycle per word.
REQ-012 mem_addr  output  ADDR_W  memory word address.
REQ-013 mem_wdata  output  DATA_W  memory write data.
REQ-014 core_reset  output  1  active-high reset to processor core.
REQ-015 done  output  1  image loaded and RUN_CYCLES elapsed.
REQ-016 error  output  1  image exceeded 2**ADDR_W words.
REQ-017 load_count  output  ADDR_W+1  words accepted in current load.

Function
REQ-018 States: LOAD, RUN, DONE, ERROR; reset enters LOAD.
REQ-019 in_ready = 1 only in LOAD; accept = in_valid & in_ready.
REQ-020 Accept at cycle T -> mem_we=1, mem_addr=write pointer, mem_wdata=in_data at T+1; mem_we=0 otherwise.
REQ-021 Write pointer starts at 0, increments by 1 per accept; load_count increments per accept.
REQ-022 Accept with in_last=1 -> LOAD to RUN at T+1; in_ready=0 from T+1.
REQ-023 Accept at pointer 2**ADDR_W-1 with in_last=0 -> ERROR at T+1; the word is still written; no pointer wrap-around.
REQ-024 Accept at pointer 2**ADDR_W-1 with in_last=1 -> RUN (legal full image).
REQ-025 core_reset = 1 in LOAD, ERROR, and first RUN cycle; deasserts at T+2 after last accept, once last write is committed.
REQ-026 Run counter counts cycles with core_reset=0 in RUN; after RUN_CYCLES such cycles -> DONE; done=1 at T+2+RUN_CYCLES.
REQ-027 DONE: done=1 (level), core_reset=0, in_ready=0, mem_we=0; state held until reload or reset.
REQ-028 ERROR: error=1 (level), core_reset=1, in_ready=0, mem_we=0 after the final write; held until reload or reset.
REQ-029 reload in DONE or ERROR -> LOAD next cycle: pointer=0, load_count=0, done=0, error=0, core_reset=1.
REQ-030 reload in LOAD or RUN is ignored.
REQ-031 in_valid=0 in LOAD: no write, pointer unchanged, core_reset held 1 indefinitely.
REQ-032 in_last with in_valid=0 has no effect.

Reset
REQ-033 reset=1 at any posedge, including mid-load or mid-run: next cycle state=LOAD, pointer=0, load_count=0, run counter=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0, in_ready=1.
REQ-034 reset has priority over accept and reload in the same cycle; a word presented that cycle is not written.

Structure
REQ-035 Shared package holds DATA_W and ADDR_W defaults, RUN_CYCLES default, and state encoding constants.
REQ-036 All outputs except in_ready are registered; in_ready decodes state only.
REQ-037 One sub-module is natural: run_timer (loadable down-counter with zero flag) for REQ-026.

Verification
REQ-038 Reset, stream 3 words 0x20080005, 0x20090007, 0x01095020 (last on third) -> writes to addr 0,1,2 one cycle after each accept; core_reset=0 two cycles after third accept; done=1 15 cycles after that.
REQ-039 Same image with in_valid gapped every other cycle -> identical memory contents and addresses; load_count=3.
REQ-040 Stream 64 words, last on 64th -> addr 63 written, RUN entered, error=0; stream 64 words without last -> addr 63 written, error=1, core_reset stays 1, in_ready=0.
REQ-041 Assert reset 5 cycles into RUN -> next cycle core_reset=1, in_ready=1, load_count=0; reload image -> writes restart at addr 0.
REQ-042 In DONE pulse reload -> LOAD, done=0; second 2-word image -> writes addr 0,1, done after RUN_CYCLES again; reload pulsed during RUN -> ignored.
